// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline control definitions: forwarding selects, writeback encodings, mul/div FSM states.
package pipe_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned SEL_W = 2;

   localparam logic [SEL_W-1:0] FWD_REG = 2'b00;
   localparam logic [SEL_W-1:0] FWD_MEM = 2'b01;
   localparam logic [SEL_W-1:0] FWD_WB  = 2'b10;

   localparam logic [1:0] WB_LOAD = 2'b01;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_BUSY = 2'b01,
      MD_DONE = 2'b10
   } md_state_e;

   // A producer only matters when it targets a real register (x0 is hardwired zero).
   function automatic logic reg_match(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
      return (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Operand forwarding select for one execute-stage source register.
module fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic       rst,
   input  logic [4:0] rs,
   input  logic [4:0] rdm,
   input  logic       reg_wem,
   input  logic [4:0] rdw,
   input  logic       reg_wew,
   output logic [1:0] sel
);

   // Memory stage holds the younger result, so it takes priority over writeback.
   always_comb begin
      sel = FWD_REG;
      if (!rst) begin
         if (reg_wem && reg_match(rdm, rs)) begin
            sel = FWD_MEM;
         end else if (reg_wew && reg_match(rdw, rs)) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard control: forwarding, load-use stall, branch flush and mul/div stall sequencing.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           rs1d,
   input  logic [4:0]           rs2d,
   input  logic [4:0]           rs1e,
   input  logic [4:0]           rs2e,
   input  logic [4:0]           rde,
   input  logic [1:0]           wb_ctre,
   input  logic [4:0]           rdm,
   input  logic [4:0]           rdw,
   input  logic                 reg_wem,
   input  logic                 reg_wew,
   input  logic                 taken,
   input  logic                 md_reqe,
   input  logic                 md_done,
   output logic [1:0]           rd1_ctr,
   output logic [1:0]           rd2_ctr,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 stall_e,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic                 flush_m,
   output logic                 md_start,
   output logic                 md_busy,
   output logic [CNT_WIDTH-1:0] stall_cnt
);

   md_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic                 load_use;
   logic                 md_hold;

   fwd_unit u_fwd_rs1 (
      .rst     (rst),
      .rs      (rs1e),
      .rdm     (rdm),
      .reg_wem (reg_wem),
      .rdw     (rdw),
      .reg_wew (reg_wew),
      .sel     (rd1_ctr)
   );

   fwd_unit u_fwd_rs2 (
      .rst     (rst),
      .rs      (rs2e),
      .rdm     (rdm),
      .reg_wem (reg_wem),
      .rdw     (rdw),
      .reg_wew (reg_wew),
      .sel     (rd2_ctr)
   );

   // Priority: mul/div hold, then taken redirect, then load-use bubble.
   always_comb begin
      load_use = (wb_ctre == WB_LOAD) && (reg_match(rde, rs1d) || reg_match(rde, rs2d));
      md_hold  = ((state_q == MD_IDLE) && md_reqe && !taken) || (state_q == MD_BUSY);
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      flush_m  = 1'b0;
      md_start = 1'b0;
      if (!rst) begin
         if (md_hold) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            flush_m  = 1'b1;
            md_start = (state_q == MD_IDLE);
         end else if (taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   // DONE always returns to IDLE so the finishing op cannot retrigger the unit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (md_reqe && !taken) state_d = MD_BUSY;
         MD_BUSY: if (md_done) state_d = MD_DONE;
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_f && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= MD_IDLE;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign md_busy   = (state_q != MD_IDLE);
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vectors, multi-cycle sequences, randomized model comparison.
module tb_pipe_ctrl;

   localparam int unsigned CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [4:0]    rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
   logic [1:0]    wb_ctre;
   logic          reg_wem, reg_wew, taken, md_reqe, md_done;
   logic [1:0]    rd1_ctr, rd2_ctr;
   logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_start, md_busy;
   logic [CW-1:0] stall_cnt;
   logic [10:0]   outv;

   assign outv = {rd1_ctr, rd2_ctr, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_start};

   pipe_ctrl #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
      .wb_ctre(wb_ctre), .rdm(rdm), .rdw(rdw), .reg_wem(reg_wem), .reg_wew(reg_wew),
      .taken(taken), .md_reqe(md_reqe), .md_done(md_done),
      .rd1_ctr(rd1_ctr), .rd2_ctr(rd2_ctr), .stall_f(stall_f), .stall_d(stall_d),
      .stall_e(stall_e), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
      .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   int checks = 0;
   int errors = 0;
   int n_start, n_stall;

   // Reference model: is a mul/div op in flight, did one just finish, stall cycles seen.
   bit m_running, m_finished;
   int m_cnt;

   typedef struct {
      string      name;
      logic       r;
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
      logic [1:0] wb;
      logic [4:0] rdm;
      logic       wem;
      logic [4:0] rdw;
      logic       wew, tk, mdr, mdd;
      logic [10:0] exp;
   } vec_t;

   vec_t tab[12];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (reg_wem && rdm != 0 && rdm == rs) return 2'b01;
      if (reg_wew && rdw != 0 && rdw == rs) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [10:0] model_out();
      logic [10:0] e;
      logic start, lu;
      e = '0;
      if (rst) return e;
      e[10:9] = exp_fwd(rs1e);
      e[8:7]  = exp_fwd(rs2e);
      start = !m_running && !m_finished && md_reqe && !taken;
      lu = (wb_ctre == 2'b01) && (rde != 0) && ((rde == rs1d) || (rde == rs2d));
      if (start || m_running) begin
         e[6:4] = 3'b111;
         e[1]   = 1'b1;
         e[0]   = start;
      end else if (taken) begin
         e[3:2] = 2'b11;
      end else if (lu) begin
         e[6:5] = 2'b11;
         e[2]   = 1'b1;
      end
      return e;
   endfunction

   task automatic model_step(input logic [10:0] e);
      logic start;
      if (rst) begin
         m_running = 0; m_finished = 0; m_cnt = 0;
      end else begin
         start = !m_running && !m_finished && md_reqe && !taken;
         if (e[6] && m_cnt < CNT_MAX) m_cnt++;
         if (start) m_running = 1;
         else if (m_running) begin
            if (md_done) begin m_running = 0; m_finished = 1; end
         end else m_finished = 0;
      end
   endtask

   // Inputs are already applied; sample outputs mid-cycle, then clock and check state.
   task automatic run_cycle(input string name, input bit use_tab, input logic [10:0] tab_exp);
      logic [10:0] e;
      #1;
      e = model_out();
      check(name, 32'(outv), 32'(use_tab ? tab_exp : e));
      if (md_start) n_start++;
      if (stall_f) n_stall++;
      model_step(e);
      @(posedge clk);
      #1;
      check({name, "_cnt"}, 32'(stall_cnt), 32'(m_cnt));
      check({name, "_busy"}, 32'(md_busy), 32'(m_running || m_finished));
   endtask

   task automatic drive(input logic r, input logic mdr, input logic mdd, input logic tk);
      rst = r; md_reqe = mdr; md_done = mdd; taken = tk;
      rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
      wb_ctre = 0; reg_wem = 0; reg_wew = 0;
   endtask

   task automatic apply_vec(input vec_t v);
      rst = v.r; rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e; rde = v.rde;
      wb_ctre = v.wb; rdm = v.rdm; reg_wem = v.wem; rdw = v.rdw; reg_wew = v.wew;
      taken = v.tk; md_reqe = v.mdr; md_done = v.mdd;
   endtask

   initial begin
      drive(1, 0, 0, 0);
      m_running = 0; m_finished = 0; m_cnt = 0; n_start = 0; n_stall = 0;
      @(posedge clk); @(posedge clk); #1;

      // name, rst, rs1d, rs2d, rs1e, rs2e, rde, wb, rdm, wem, rdw, wew, taken, md_reqe, md_done, {rd1,rd2,sf sd se,fd fe fm,start}
      tab[0]  = '{"reset",    1'b1, 5'd0, 5'd7, 5'd5, 5'd5, 5'd7, 2'b01, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 11'b00_00_000_000_0};
      tab[1]  = '{"fwd_mem",  1'b0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 11'b01_00_000_000_0};
      tab[2]  = '{"fwd_wb",   1'b0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 11'b10_00_000_000_0};
      tab[3]  = '{"fwd_x0",   1'b0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 2'b00, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 11'b00_01_000_000_0};
      tab[4]  = '{"fwd_wb2",  1'b0, 5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 2'b00, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 11'b10_10_000_000_0};
      tab[5]  = '{"fwd_mix",  1'b0, 5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 2'b00, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 11'b01_10_000_000_0};
      tab[6]  = '{"lu_rs2",   1'b0, 5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_110_010_0};
      tab[7]  = '{"lu_rd0",   1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_000_000_0};
      tab[8]  = '{"lu_rs1",   1'b0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_110_010_0};
      tab[9]  = '{"no_load",  1'b0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 2'b10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_000_000_0};
      tab[10] = '{"lu_taken", 1'b0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00_00_000_110_0};
      tab[11] = '{"taken",    1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00_00_000_110_0};

      for (int i = 0; i < 12; i++) begin
         apply_vec(tab[i]);
         run_cycle(tab[i].name, 1'b1, tab[i].exp);
      end

      // Mul/div op: start, four busy cycles with done on the last, DONE, IDLE.
      drive(1, 0, 0, 0); run_cycle("seqa_rst", 1'b0, '0);
      n_start = 0; n_stall = 0;
      drive(0, 1, 0, 0); run_cycle("md_start", 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, (i == 3), 0); run_cycle("md_wait", 1'b0, '0);
      end
      drive(0, 1, 0, 0); run_cycle("md_done_st", 1'b0, '0);
      drive(0, 0, 0, 0); run_cycle("md_idle", 1'b0, '0);
      check("md_start_pulses", 32'(n_start), 32'd1);
      check("md_stall_cycles", 32'(n_stall), 32'd5);
      check("md_stall_cnt", 32'(stall_cnt), 32'd5);
      check("md_busy_end", 32'(md_busy), 32'd0);

      // Reset mid-operation abandons it; a late md_done is ignored.
      drive(1, 0, 0, 0); run_cycle("seqb_rst", 1'b0, '0);
      drive(0, 1, 0, 0); run_cycle("rb_start", 1'b0, '0);
      drive(0, 1, 0, 0); run_cycle("rb_wait", 1'b0, '0);
      drive(0, 1, 0, 0); run_cycle("rb_wait", 1'b0, '0);
      drive(1, 1, 0, 0); run_cycle("rst_in_busy", 1'b0, '0);
      check("rb_busy", 32'(md_busy), 32'd0);
      check("rb_cnt", 32'(stall_cnt), 32'd0);
      drive(0, 0, 1, 0); run_cycle("late_done", 1'b0, '0);
      check("late_done_busy", 32'(md_busy), 32'd0);

      // Long stall saturates the counter.
      drive(0, 1, 0, 0);
      for (int i = 0; i < 20; i++) run_cycle("sat_wait", 1'b0, '0);
      check("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
      drive(1, 0, 0, 0); run_cycle("sat_rst", 1'b0, '0);

      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 49) == 0);
         rs1d    = 5'($urandom_range(0, 7));
         rs2d    = 5'($urandom_range(0, 7));
         rs1e    = 5'($urandom_range(0, 7));
         rs2e    = 5'($urandom_range(0, 7));
         rde     = 5'($urandom_range(0, 7));
         rdm     = 5'($urandom_range(0, 7));
         rdw     = 5'($urandom_range(0, 7));
         wb_ctre = 2'($urandom_range(0, 3));
         reg_wem = 1'($urandom_range(0, 1));
         reg_wew = 1'($urandom_range(0, 1));
         taken   = ($urandom_range(0, 5) == 0);
         md_reqe = ($urandom_range(0, 3) == 0);
         md_done = ($urandom_range(0, 3) == 0);
         run_cycle("rand", 1'b0, '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of the stall-cycle counter.
REQ-002 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have rs1d, rs2d  in  5 each  source registers of the instruction in decode.
REQ-005 SHALL have rs1e, rs2e, rde  in  5 each  sources and destination of the instruction in execute.
REQ-006 SHALL have wb_ctre  in  2  execute-stage writeback select; 2'b01 = load.
REQ-007 SHALL have rdm, rdw  in  5 each; reg_wem, reg_wew  in  1 each  destination and write enable in memory and writeback stages.
REQ-008 SHALL have taken  in  1  branch/jump resolved taken in execute.
REQ-009 SHALL have md_reqe  in  1  execute holds a multi-cycle mul/div op; md_done  in  1  one-cycle completion pulse from the mul/div unit.
REQ-010 SHALL have rd1_ctr, rd2_ctr  out  2 each  forwarding select: 00 register file, 01 memory-stage ALU result, 10 writeback result.
REQ-011 SHALL have stall_f, stall_d, stall_e  out  1 each  hold the PC, IF/ID, and ID/EX registers.
REQ-012 SHALL have flush_d, flush_e, flush_m  out  1 each  bubble into IF/ID, ID/EX, EX/MEM.
REQ-013 SHALL have md_start  out  1  one-cycle start pulse; md_busy  out  1  FSM not IDLE; stall_cnt  out  CNT_WIDTH  cycles with stall_f high.

Function
REQ-014 rd1_ctr SHALL be 01 when reg_wem, rdm!=0, rdm==rs1e; else 10 when reg_wew, rdw!=0, rdw==rs1e; else 00 (memory stage wins over writeback); rd2_ctr identical using rs2e.
REQ-015 Load-use hazard SHALL be wb_ctre==01, rde!=0, rde==rs1d or rde==rs2d; response: stall_f=stall_d=1, flush_e=1, for exactly that cycle.
REQ-016 taken SHALL assert flush_d=flush_e=1 and suppress load-use stall in the same cycle (taken wins).
REQ-017 Mul/div FSM states: IDLE, BUSY, DONE.
REQ-018 IDLE, md_reqe=1, taken=0: md_start=1 for one cycle, next BUSY; stall_f=stall_d=stall_e=1, flush_m=1 that cycle.
REQ-019 BUSY: stall_f=stall_d=stall_e=1, flush_m=1, md_start=0; md_done=1 -> DONE, else stay.
REQ-020 DONE: no stalls, no flush_m, EX advances; next IDLE unconditionally; md_reqe in DONE SHALL NOT restart the unit.
REQ-021 md_done outside BUSY SHALL be ignored.
REQ-022 While BUSY or in the IDLE start cycle, load-use and taken responses SHALL be masked (stall dominates); taken is re-evaluated in DONE.
REQ-023 Forwarding selects SHALL be valid in all FSM states.
REQ-024 stall_cnt SHALL increment by 1 each cycle stall_f=1, saturating at all-ones.
REQ-025 All outputs except stall_cnt and md_busy SHALL be combinational from inputs and FSM state; zero-latency.

Reset
REQ-026 rst=1 SHALL force FSM to IDLE and stall_cnt to 0 on the next edge.
REQ-027 While rst=1, stall_*, flush_*, md_start SHALL be 0 and rd1_ctr=rd2_ctr=00; md_busy=0 after the reset edge.
REQ-028 rst during BUSY SHALL abandon the operation; a later md_done SHALL be ignored.

Structure
REQ-029 Forwarding encodings (FWD_REG/FWD_MEM/FWD_WB), WB_LOAD and FSM state encoding SHALL live in the shared pipeline package.
REQ-030 Forwarding logic SHALL be one sub-module, fwd_unit, instantiated once per source operand.

Verification
REQ-031 rs1e=5, rdm=5 reg_wem=1, rdw=5 reg_wew=1 -> rd1_ctr=01; rdm=0 same case -> rd1_ctr=10; rs1e=0 -> 00.
REQ-032 wb_ctre=01, rde=7, rs2d=7 -> one cycle stall_f=stall_d=flush_e=1, stall_cnt +1; rde=0 -> no stall.
REQ-033 Load-use plus taken same cycle -> flush_d=flush_e=1, stall_f=0.
REQ-034 md_reqe=1, md_done after 4 BUSY cycles -> md_start one pulse, stalls high 5 cycles, DONE cycle no stall, then IDLE, stall_cnt=5.
REQ-035 rst asserted in BUSY -> IDLE next edge, stall_cnt=0; md_done next cycle -> no state change.
